// File: rtl/sram_cluster_xbar.sv
// Banked SRAM cluster with per-port 2-cycle read pipelines, a runtime bank ownership
// table and a control-plane write port that yields to owner reads on the same bank.
module sram_cluster_xbar #(
    parameter int NUM_BANKS = 16,
    parameter int NUM_PORTS = 4,
    parameter int DATA_W    = 64,
    parameter int ADDR_W    = 8,
    parameter int BANK_W    = $clog2(NUM_BANKS),
    parameter int PORT_W    = $clog2(NUM_PORTS)
) (
    input  logic                          clock,
    input  logic                          reset,
    input  logic                          cfg_wr_en,
    input  logic [BANK_W-1:0]             cfg_bank,
    input  logic [PORT_W-1:0]             cfg_owner,
    input  logic                          cfg_enable,
    input  logic [NUM_PORTS-1:0]          rd_req_valid,
    input  logic [NUM_PORTS*BANK_W-1:0]   rd_req_bank,
    input  logic [NUM_PORTS*ADDR_W-1:0]   rd_req_addr,
    output logic [NUM_PORTS-1:0]          rd_resp_valid,
    output logic [NUM_PORTS-1:0]          rd_resp_err,
    output logic [NUM_PORTS*DATA_W-1:0]   rd_resp_data,
    input  logic                          wr_valid,
    output logic                          wr_ready,
    input  logic [BANK_W-1:0]             wr_bank,
    input  logic [ADDR_W-1:0]             wr_addr,
    input  logic [DATA_W-1:0]             wr_data
);
    localparam int DEPTH = 1 << ADDR_W;

    logic              tbl_en    [NUM_BANKS];
    logic [PORT_W-1:0] tbl_owner [NUM_BANKS];

    logic [BANK_W-1:0] req_bank [NUM_PORTS];
    logic [ADDR_W-1:0] req_addr [NUM_PORTS];
    logic [NUM_PORTS-1:0] req_ok;

    logic [NUM_PORTS-1:0] s1_valid, s1_ok, s2_valid, s2_ok;
    logic [BANK_W-1:0]    s1_bank [NUM_PORTS];
    logic [ADDR_W-1:0]    s1_addr [NUM_PORTS];
    logic [BANK_W-1:0]    s2_bank [NUM_PORTS];

    logic [NUM_BANKS-1:0] bank_re, bank_we;
    logic [ADDR_W-1:0]    bank_raddr [NUM_BANKS];
    logic [DATA_W-1:0]    bank_q     [NUM_BANKS];
    logic [DATA_W-1:0]    mem        [NUM_BANKS][DEPTH];
    logic                 wr_fire;

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clock) begin
        if (reset) begin
            for (int b = 0; b < NUM_BANKS; b++) begin
                tbl_en[b]    <= 1'b0;
                tbl_owner[b] <= '0;
            end
        end else if (cfg_wr_en) begin
            tbl_en[cfg_bank]    <= cfg_enable;
            tbl_owner[cfg_bank] <= cfg_owner;
        end
    end

    // NOTE: every signal driven in always_comb gets a default first, so no latch is inferred.
    always_comb begin
        req_ok = '0;
        for (int p = 0; p < NUM_PORTS; p++) begin
            req_bank[p] = rd_req_bank[p*BANK_W +: BANK_W];
            req_addr[p] = rd_req_addr[p*ADDR_W +: ADDR_W];
            req_ok[p]   = tbl_en[req_bank[p]] && (tbl_owner[req_bank[p]] == PORT_W'(p));
        end
    end

    // Only pipeline valids are reset; payload fields are qualified by them.
    always_ff @(posedge clock) begin
        if (reset) begin
            s1_valid <= '0;
            s2_valid <= '0;
        end else begin
            s1_valid <= rd_req_valid;
            s2_valid <= s1_valid;
        end
    end

    always_ff @(posedge clock) begin
        s1_ok <= req_ok;
        s2_ok <= s1_ok;
        for (int p = 0; p < NUM_PORTS; p++) begin
            s1_bank[p] <= req_bank[p];
            s1_addr[p] <= req_addr[p];
            s2_bank[p] <= s1_bank[p];
        end
    end

    // A bank has a single owner, so at most one stage-1 entry selects any bank.
    always_comb begin
        bank_re  = '0;
        wr_ready = 1'b1;
        for (int b = 0; b < NUM_BANKS; b++) bank_raddr[b] = '0;
        for (int p = 0; p < NUM_PORTS; p++) begin
            if (s1_valid[p] && s1_ok[p]) begin
                bank_re[s1_bank[p]]    = 1'b1;
                bank_raddr[s1_bank[p]] = s1_addr[p];
                if (s1_bank[p] == wr_bank) wr_ready = 1'b0;
            end
        end
    end

    assign wr_fire = wr_valid && wr_ready && !reset;

    always_comb begin
        bank_we = '0;
        if (wr_fire) bank_we[wr_bank] = 1'b1;
    end

    // NOTE: SRAM arrays and their read registers carry no reset; contents survive reset.
    always_ff @(posedge clock) begin
        for (int b = 0; b < NUM_BANKS; b++) begin
            if (bank_we[b])      mem[b][wr_addr] <= wr_data;
            else if (bank_re[b]) bank_q[b]       <= mem[b][bank_raddr[b]];
        end
    end

    always_comb begin
        rd_resp_valid = s2_valid;
        rd_resp_err   = s2_valid & ~s2_ok;
        rd_resp_data  = '0;
        for (int p = 0; p < NUM_PORTS; p++) begin
            if (s2_valid[p] && s2_ok[p]) rd_resp_data[p*DATA_W +: DATA_W] = bank_q[s2_bank[p]];
        end
    end

endmodule

// File: tb/tb_sram_cluster_xbar.sv
// Self-checking bench for sram_cluster_xbar: directed vector table, hand sequences for
// multi-cycle corners, and randomized traffic scored against a cycle-level reference model.
module tb_sram_cluster_xbar;
    localparam int NB = 16, NP = 4, DW = 64, AW = 8, BW = 4, PWD = 2, DEPTH = 256;

    logic clock = 1'b0;
    always #5 clock = ~clock;

    logic              reset;
    logic              cfg_wr_en, cfg_enable;
    logic [BW-1:0]     cfg_bank;
    logic [PWD-1:0]    cfg_owner;
    logic [NP-1:0]     rd_req_valid, rd_resp_valid, rd_resp_err;
    logic [NP*BW-1:0]  rd_req_bank;
    logic [NP*AW-1:0]  rd_req_addr;
    logic [NP*DW-1:0]  rd_resp_data;
    logic              wr_valid, wr_ready;
    logic [BW-1:0]     wr_bank;
    logic [AW-1:0]     wr_addr;
    logic [DW-1:0]     wr_data;

    sram_cluster_xbar #(.NUM_BANKS(NB), .NUM_PORTS(NP), .DATA_W(DW), .ADDR_W(AW)) dut (
        .clock(clock), .reset(reset),
        .cfg_wr_en(cfg_wr_en), .cfg_bank(cfg_bank), .cfg_owner(cfg_owner), .cfg_enable(cfg_enable),
        .rd_req_valid(rd_req_valid), .rd_req_bank(rd_req_bank), .rd_req_addr(rd_req_addr),
        .rd_resp_valid(rd_resp_valid), .rd_resp_err(rd_resp_err), .rd_resp_data(rd_resp_data),
        .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_bank(wr_bank), .wr_addr(wr_addr),
        .wr_data(wr_data)
    );

    int n_cmp = 0, n_bad = 0;

    // Reference model: ownership table, memory image, requests issued last cycle,
    // and the responses expected on the outputs this cycle.
    bit          t_en  [NB];
    int          t_own [NB];
    bit          pv [NP], pok [NP];
    int          pb [NP], pa [NP];
    bit          ev [NP], ee [NP], ek [NP];
    logic [DW-1:0] ed [NP];
    logic [DW-1:0] mm [int];
    bit          armed = 1'b0;
    logic        last_wr_ready;

    typedef struct {
        int          port;
        int          bank;
        int          addr;
        bit          err;
        logic [DW-1:0] data;
    } vec_t;
    vec_t vecs[$];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic idle();
        reset = 1'b0; cfg_wr_en = 1'b0; cfg_bank = '0; cfg_owner = '0; cfg_enable = 1'b0;
        rd_req_valid = '0; rd_req_bank = '0; rd_req_addr = '0;
        wr_valid = 1'b0; wr_bank = '0; wr_addr = '0; wr_data = '0;
    endtask

    task automatic rd(input int p, input int bank, input int addr);
        rd_req_valid[p] = 1'b1;
        rd_req_bank[p*BW +: BW] = BW'(bank);
        rd_req_addr[p*AW +: AW] = AW'(addr);
    endtask

    task automatic wr(input int bank, input int addr, input logic [DW-1:0] data);
        wr_valid = 1'b1; wr_bank = BW'(bank); wr_addr = AW'(addr); wr_data = data;
    endtask

    task automatic cfg(input int bank, input int owner, input bit en);
        cfg_wr_en = 1'b1; cfg_bank = BW'(bank); cfg_owner = PWD'(owner); cfg_enable = en;
    endtask

    // One clock cycle: score outputs against the model, advance the model, then clock.
    task automatic cycle();
        bit exp_rdy;
        int key;
        #1;
        last_wr_ready = wr_ready;
        exp_rdy = 1'b1;
        for (int p = 0; p < NP; p++)
            if (pv[p] && pok[p] && pb[p] == int'(wr_bank)) exp_rdy = 1'b0;
        if (armed) begin
            for (int p = 0; p < NP; p++) begin
                check($sformatf("model valid p%0d", p), 64'(rd_resp_valid[p]), 64'(ev[p]));
                check($sformatf("model err p%0d", p), 64'(rd_resp_err[p]), 64'(ee[p]));
                if (ek[p]) check($sformatf("model data p%0d", p), rd_resp_data[p*DW +: DW], ed[p]);
            end
            check("model wr_ready", 64'(wr_ready), 64'(exp_rdy));
        end
        if (reset) begin
            for (int b = 0; b < NB; b++) begin t_en[b] = 1'b0; t_own[b] = 0; end
            for (int p = 0; p < NP; p++) begin
                pv[p] = 1'b0; ev[p] = 1'b0; ee[p] = 1'b0; ek[p] = 1'b1; ed[p] = '0;
            end
            armed = 1'b1;
        end else begin
            for (int p = 0; p < NP; p++) begin
                ev[p] = pv[p];
                ee[p] = pv[p] && !pok[p];
                ed[p] = '0;
                ek[p] = 1'b1;
                if (pv[p] && pok[p]) begin
                    key   = pb[p] * DEPTH + pa[p];
                    ek[p] = mm.exists(key);
                    if (ek[p]) ed[p] = mm[key];
                end
            end
            for (int p = 0; p < NP; p++) begin
                pv[p]  = rd_req_valid[p];
                pb[p]  = int'(rd_req_bank[p*BW +: BW]);
                pa[p]  = int'(rd_req_addr[p*AW +: AW]);
                pok[p] = t_en[pb[p]] && t_own[pb[p]] == p;
            end
            if (wr_valid && exp_rdy) mm[int'(wr_bank) * DEPTH + int'(wr_addr)] = wr_data;
            if (cfg_wr_en) begin
                t_en[cfg_bank]  = cfg_enable;
                t_own[cfg_bank] = int'(cfg_owner);
            end
        end
        @(posedge clock);
        #1;
        idle();
    endtask

    initial begin
        idle();
        for (int p = 0; p < NP; p++) begin pv[p] = 0; ev[p] = 0; ee[p] = 0; ek[p] = 1; ed[p] = '0; end

        reset = 1'b1; cycle();
        reset = 1'b1; cycle();
        check("reset valid", 64'(rd_resp_valid), 64'h0);
        check("reset err", 64'(rd_resp_err), 64'h0);
        check("reset data", 64'(|rd_resp_data), 64'h0);

        // Setup: bank 3 owned by port 2, bank 15 owned by port 3, a few known entries.
        wr(3, 'h10, 64'hDEADBEEF_00000001); cfg(3, 2, 1'b1); cycle();
        check("reset wr_ready", 64'(last_wr_ready), 64'h1);
        wr(3, 'h00, 64'h1234); cycle();
        wr(3, 'hFF, 64'h5555); cycle();
        wr(15, 'hFF, 64'hF00D); cfg(15, 3, 1'b1); cycle();

        vecs.push_back('{2, 3,  'h10, 1'b0, 64'hDEADBEEF_00000001});
        vecs.push_back('{1, 3,  'h10, 1'b1, 64'h0});
        vecs.push_back('{0, 5,  'h00, 1'b1, 64'h0});
        vecs.push_back('{2, 3,  'h00, 1'b0, 64'h1234});
        vecs.push_back('{2, 3,  'hFF, 1'b0, 64'h5555});
        vecs.push_back('{3, 15, 'hFF, 1'b0, 64'hF00D});
        vecs.push_back('{0, 15, 'hFF, 1'b1, 64'h0});
        foreach (vecs[i]) begin
            rd(vecs[i].port, vecs[i].bank, vecs[i].addr);
            cycle();
            cycle();
            check($sformatf("vec%0d valid", i), 64'(rd_resp_valid), 64'(1 << vecs[i].port));
            check($sformatf("vec%0d err", i), 64'(rd_resp_err[vecs[i].port]), 64'(vecs[i].err));
            check($sformatf("vec%0d data", i), rd_resp_data[vecs[i].port*DW +: DW], vecs[i].data);
        end

        // Two non-owner requests in the same cycle.
        rd(1, 3, 'h10); rd(0, 5, 'h00); cycle(); cycle();
        check("dual err", 64'(rd_resp_err), 64'h3);
        check("dual valid", 64'(rd_resp_valid), 64'h3);
        check("dual data", 64'(|rd_resp_data), 64'h0);

        // Writes to a bank under continuous owner reads stall; other banks proceed.
        for (int k = 0; k <= 11; k++) begin
            if (k <= 9) rd(2, 3, 'h10);
            if (k >= 1) begin
                if (k == 5) wr(4, 'h30, 64'h4444);
                else        wr(3, 'h30, 64'hBEEF);
            end
            cycle();
            if (k >= 1) check($sformatf("stall k%0d", k), 64'(last_wr_ready), 64'(k == 5 || k == 11));
        end
        cycle(); cycle();

        // Read right after a committed write sees the new data.
        wr(3, 'h20, 64'hA); cycle();
        check("raw wr_ready", 64'(last_wr_ready), 64'h1);
        rd(2, 3, 'h20); cycle(); cycle();
        check("raw data", rd_resp_data[2*DW +: DW], 64'hA);
        check("raw err", 64'(rd_resp_err[2]), 64'h0);
        rd(2, 3, 'h30); cycle(); cycle();
        check("stalled write data", rd_resp_data[2*DW +: DW], 64'hBEEF);

        // Ownership change: request in the config cycle uses the old owner.
        cfg(3, 1, 1'b1); rd(2, 3, 'h10); cycle();
        rd(2, 3, 'h10); rd(1, 3, 'h20); cycle();
        check("cfg old err", 64'(rd_resp_err[2]), 64'h0);
        check("cfg old data", rd_resp_data[2*DW +: DW], 64'hDEADBEEF_00000001);
        cycle();
        check("cfg new p2 err", 64'(rd_resp_err[2]), 64'h1);
        check("cfg new p2 data", rd_resp_data[2*DW +: DW], 64'h0);
        check("cfg new p1 data", rd_resp_data[1*DW +: DW], 64'hA);
        check("cfg new valid", 64'(rd_resp_valid), 64'h6);

        // Randomized traffic against the model.
        for (int b = 0; b < NB; b++) begin
            cfg(b, $urandom_range(0, NP - 1), $urandom_range(0, 3) != 0); cycle();
        end
        for (int b = 0; b < NB; b++)
            for (int a = 0; a <= 16; a++) begin
                wr(b, (a == 16) ? 255 : a, {$urandom, $urandom}); cycle();
            end
        for (int n = 0; n < 400; n++) begin
            for (int p = 0; p < NP; p++)
                if ($urandom_range(0, 9) < 7)
                    rd(p, $urandom_range(0, NB - 1), ($urandom_range(0, 3) == 0) ? 255 : $urandom_range(0, 15));
            if ($urandom_range(0, 9) < 3)
                wr($urandom_range(0, NB - 1), $urandom_range(0, 15), {$urandom, $urandom});
            if ($urandom_range(0, 19) == 0)
                cfg($urandom_range(0, NB - 1), $urandom_range(0, NP - 1), $urandom_range(0, 3) != 0);
            cycle();
        end

        // Full-rate reads on all ports, then reset mid-stream.
        for (int b = 0; b < NP; b++) begin cfg(b, b, 1'b1); cycle(); end
        for (int n = 0; n < 20; n++) begin
            for (int p = 0; p < NP; p++) rd(p, p, $urandom_range(0, 15));
            cycle();
        end
        for (int p = 0; p < NP; p++) rd(p, p, 0);
        wr(7, 0, 64'h77);
        reset = 1'b1; cycle();
        check("post reset valid", 64'(rd_resp_valid), 64'h0);
        for (int p = 0; p < NP; p++) rd(p, p, 0);
        cycle(); cycle();
        check("post reset err", 64'(rd_resp_err), 64'hF);
        check("post reset data", 64'(|rd_resp_data), 64'h0);
        cycle(); cycle();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/sram_cluster_xbar.md
Name: sram_cluster_xbar

Overview:
- Parametrised successor to the fixed 16-bank SRAM cluster.
- Holds NUM_BANKS single-port synchronous SRAM banks, each DEPTH x DATA_W.
- Exposes NUM_PORTS read ports, one per pipeline stage; a runtime ownership table maps each bank to one owning port.
- A control-plane write port with valid/ready handshake updates table contents, arbitrated against reads per bank.

Parameters:
NUM_BANKS, 16, number of SRAM banks; power of 2, at least 2
NUM_PORTS, 4, number of read ports; power of 2, at least 2
DATA_W, 64, entry width in bits
ADDR_W, 8, entry address width; DEPTH = 2^ADDR_W
BANK_W, log2(NUM_BANKS), derived bank-select width
PORT_W, log2(NUM_PORTS), derived port-select width

Ports:
clock  in  1  single clock; all logic rising-edge
reset  in  1  synchronous, active-high
cfg_wr_en  in  1  ownership-table write strobe
cfg_bank  in  BANK_W  bank being configured
cfg_owner  in  PORT_W  owning read port
cfg_enable  in  1  1 = bank enabled for reads
rd_req_valid  in  NUM_PORTS  per-port read request
rd_req_bank  in  NUM_PORTS*BANK_W  per-port bank; port p uses slice p
rd_req_addr  in  NUM_PORTS*ADDR_W  per-port entry address
rd_resp_valid  out  NUM_PORTS  per-port response valid
rd_resp_err  out  NUM_PORTS  1 = request to a bank not enabled or not owned by this port
rd_resp_data  out  NUM_PORTS*DATA_W  per-port read data
wr_valid  in  1  write request
wr_ready  out  1  write accepted when wr_valid and wr_ready are both 1
wr_bank  in  BANK_W  target bank
wr_addr  in  ADDR_W  target entry
wr_data  in  DATA_W  write data

Behaviour:
- Reset:
  - All ownership entries become enabled=0, owner=0.
  - The stage-1 and stage-2 pipeline valids clear.
  - rd_resp_valid=0, rd_resp_err=0 and rd_resp_data=0 from the first cycle after reset is sampled.
  - SRAM contents are not cleared.
  - Reset mid-operation drops all in-flight reads with no response and drops any write not yet committed.
- Config:
  - A cfg_wr_en at cycle T updates the table at the edge ending T.
  - Requests presented at T+1 and later use the new mapping; a request at T uses the old one.
  - In-flight requests never change outcome.
- Read pipeline, fixed latency 2, one request per port per cycle, no backpressure:
  - Cycle T: request sampled. ok = bank enabled and owner equals this port. Stage 1 registers valid, bank, addr and ok.
  - Cycle T+1: if stage-1 valid and ok, drive that bank's read enable and address. Only the owner can access a bank, so there is never a read conflict between ports.
  - Cycle T+2: rd_resp_valid=1. If ok: rd_resp_data = bank[addr] and rd_resp_err=0. If not ok: data=0, err=1, and no SRAM access.
  - rd_resp_valid=0 in any cycle with no response; data holds 0 in that case.
- Write:
  - wr_ready = 0 when any stage-1 entry is valid, ok, and targets wr_bank; otherwise 1.
  - wr_ready is combinational from stage-1 state and wr_bank. wr_ready must not depend on wr_valid.
  - An accepted write commits at the edge ending the accept cycle. Writes ignore ownership.
  - A read whose bank access (stage 1) falls after the commit cycle returns the new data.
  - A read in stage 1 during the accept cycle is impossible to the same bank, by construction.
- Throughput: every port can sustain 1 read per cycle. A blocked write stalls only while its bank is being read; there is no starvation guarantee. Software quiesces the owner for bulk updates.
- Widths: bank/addr slices are taken exactly from the packed vectors, with no wrap-around. All of 0..DEPTH-1 is addressable.

Test Plan:
1. Reset, then write bank 3 addr 0x10 = 0xDEADBEEF_00000001; cfg bank3 -> port2, enabled. Port 2 reads bank3/0x10 at T -> rd_resp_valid[2]=1 at T+2, data 0xDEADBEEF_00000001, err=0.
2. Port 1 reads bank 3 (owned by port 2); port 0 reads disabled bank 5 -> both respond at T+2 with err=1, data=0; no SRAM read enable asserted.
3. Port 2 reads bank3 every cycle for 10 cycles while wr_valid targets bank3 -> wr_ready=0 throughout. Write to bank 4 is accepted in the same window. Stop reads -> bank3 write is accepted next cycle.
4. Write bank3/0x20 = 0xA accepted at cycle T; port 2 reads bank3/0x20 at T+1 -> response at T+3 = 0xA.
5. Cfg bank3 -> port1 at T while port 2 requests bank3 at T and T+1 -> T request ok, T+1 request err=1. Port 1 request at T+1 is ok.
6. All 4 ports read 4 distinct owned banks each cycle for 20 cycles, then reset is asserted mid-stream -> no rd_resp_valid in the cycle after reset. Post-reset reads return err=1 because the ownership table is cleared.
